// File: rtl/cache_unit.sv
// Direct-mapped, write-back, write-allocate data cache with a 128-bit line port, plus the
// data_memory backing store. Define CACHE_PERF_CNT_EN to add saturating hit/miss counters.
module cache_unit #(
    parameter int NUM_LINES   = 64,
    parameter int MEM_LATENCY = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  address,
    input  logic         read_in,
    input  logic         write_in,
    input  logic [31:0]  write_data_in,
    output logic [31:0]  read_data,
    output logic         mem_access_status,
    output logic [4:0]   countR,
    output logic [31:0]  mem_read_address,
    input  logic [127:0] mem_input,
    output logic         mem_write,
    output logic [31:0]  mem_write_address,
`ifdef CACHE_PERF_CNT_EN
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
`endif
    output logic [127:0] mem_write_data
);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 28 - IW;
    localparam logic [4:0] LAST_COUNT = 5'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [4:0]           count_q, count_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [31:0]          read_data_q, read_data_d;
    logic                 mem_write_q, mem_write_d;
    logic [31:0]          mem_read_address_q, mem_read_address_d;
    logic [31:0]          mem_write_address_q, mem_write_address_d;
    logic [127:0]         mem_write_data_q, mem_write_data_d;

    logic [127:0]         data_mem [NUM_LINES];
    logic [TW-1:0]        tag_mem  [NUM_LINES];

    logic [1:0]           word_sel;
    logic [IW-1:0]        req_idx;
    logic [TW-1:0]        req_tag;
    logic [IW-1:0]        fill_idx;
    logic [TW-1:0]        fill_tag;
    logic [127:0]         cur_line;
    logic [127:0]         merged_line;
    logic [31:0]          sel_word;
    logic                 req;
    logic                 hit;

    logic                 line_we;
    logic [IW-1:0]        line_idx;
    logic [127:0]         line_wdata;
    logic [TW-1:0]        line_wtag;

    logic                 unused_addr;

    assign word_sel    = address[3:2];
    assign req_idx     = address[3+IW:4];
    assign req_tag     = address[31:4+IW];
    assign unused_addr = ^address[1:0];

    // The refill target is latched at miss time, so CPU address changes mid-miss are harmless.
    assign fill_idx = mem_read_address_q[3+IW:4];
    assign fill_tag = mem_read_address_q[31:4+IW];

    assign cur_line = data_mem[req_idx];
    assign sel_word = cur_line[{word_sel, 5'b0} +: 32];
    assign req      = read_in | write_in;
    assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    always_comb begin
        merged_line = cur_line;
        merged_line[{word_sel, 5'b0} +: 32] = write_data_in;
    end

    // Reads see the stored word combinationally; otherwise the last loaded word is held.
    assign read_data         = (state_q == IDLE && read_in && hit) ? sel_word : read_data_q;
    assign mem_access_status = (state_q == IDLE) ? (req & ~hit) : 1'b1;

    assign countR            = count_q;
    assign mem_write         = mem_write_q;
    assign mem_read_address  = mem_read_address_q;
    assign mem_write_address = mem_write_address_q;
    assign mem_write_data    = mem_write_data_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d             = state_q;
        count_d             = count_q;
        valid_d             = valid_q;
        dirty_d             = dirty_q;
        read_data_d         = read_data_q;
        mem_write_d         = 1'b0;
        mem_read_address_d  = mem_read_address_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        line_we             = 1'b0;
        line_idx            = req_idx;
        line_wdata          = merged_line;
        line_wtag           = req_tag;

        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (req && hit) begin
                    if (read_in) begin
                        read_data_d = sel_word;
                    end
                    if (write_in) begin
                        line_we          = 1'b1;
                        dirty_d[req_idx] = 1'b1;
                    end
                end else if (req) begin
                    mem_read_address_d = {address[31:4], 4'b0000};
                    if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d             = WRITEBACK;
                        mem_write_address_d = {tag_mem[req_idx], req_idx, 4'b0000};
                        mem_write_data_d    = cur_line;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end

            WRITEBACK: begin
                if (count_q == LAST_COUNT) begin
                    count_d           = '0;
                    dirty_d[fill_idx] = 1'b0;
                    state_d           = ALLOCATE;
                end else begin
                    count_d = count_q + 5'd1;
                    // Registered strobe lines up with the cycle in which countR reads LAST_COUNT.
                    mem_write_d = (count_d == LAST_COUNT);
                end
            end

            ALLOCATE: begin
                if (count_q == LAST_COUNT) begin
                    count_d           = '0;
                    line_we           = 1'b1;
                    line_idx          = fill_idx;
                    line_wdata        = mem_input;
                    line_wtag         = fill_tag;
                    valid_d[fill_idx] = 1'b1;
                    dirty_d[fill_idx] = 1'b0;
                    state_d           = IDLE;
                end else begin
                    count_d = count_q + 5'd1;
                end
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            count_q             <= '0;
            valid_q             <= '0;
            dirty_q             <= '0;
            read_data_q         <= '0;
            mem_write_q         <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q             <= state_d;
            count_q             <= count_d;
            valid_q             <= valid_d;
            dirty_q             <= dirty_d;
            read_data_q         <= read_data_d;
            mem_write_q         <= mem_write_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
        end
    end

    // NOTE: data and tag arrays carry no reset; the valid bits alone make them meaningful.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem[line_idx] <= line_wdata;
            tag_mem[line_idx]  <= line_wtag;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == IDLE && req && hit && hit_count_q != 32'hFFFF_FFFF) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (state_q == IDLE && req && !hit && miss_count_q != 32'hFFFF_FFFF) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// data_memory: backing store of 128-bit lines indexed by the line address; combinational read.
// ADDR_BITS selects how many line-address bits are decoded (must be below 28).
module data_memory #(
    parameter int ADDR_BITS = 10
) (
    input  logic         clk,
    input  logic         write,
    input  logic [31:0]  write_address,
    input  logic [127:0] write_data,
    input  logic [31:0]  read_address,
    input  logic [4:0]   count,
    output logic [127:0] read_data
);
    logic [127:0] lines [2**ADDR_BITS];
    logic         unused_bits;

    // Latency is modelled by the cache's counter; the array itself responds immediately.
    assign unused_bits = ^{count, write_address[3:0], read_address[3:0],
                           write_address[31:4+ADDR_BITS], read_address[31:4+ADDR_BITS]};

    always_ff @(posedge clk) begin
        if (write) begin
            lines[write_address[4 +: ADDR_BITS]] <= write_data;
        end
    end

    assign read_data = lines[read_address[4 +: ADDR_BITS]];

endmodule

// File: tb/tb_cache_unit.sv
// Directed bench for cache_unit: fills, write-back of a dirty victim, read/write collision
// and reset in the middle of a refill, against a preloaded data_memory.
module tb_cache_unit;
    localparam int LAT = 20;

    logic         clk;
    logic         rst_n;
    logic [31:0]  address;
    logic         read_in;
    logic         write_in;
    logic [31:0]  write_data_in;
    logic [31:0]  read_data;
    logic         mem_access_status;
    logic [4:0]   countR;
    logic [31:0]  mem_read_address;
    logic [127:0] mem_input;
    logic         mem_write;
    logic [31:0]  mem_write_address;
    logic [127:0] mem_write_data;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    logic         pre_we;
    logic [31:0]  pre_addr;
    logic [127:0] pre_data;
    logic         mem_we;
    logic [31:0]  mem_waddr;
    logic [127:0] mem_wdata;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic [4:0]   wb_count;

    cache_unit #(.NUM_LINES(64), .MEM_LATENCY(LAT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .address           (address),
        .read_in           (read_in),
        .write_in          (write_in),
        .write_data_in     (write_data_in),
        .read_data         (read_data),
        .mem_access_status (mem_access_status),
        .countR            (countR),
        .mem_read_address  (mem_read_address),
        .mem_input         (mem_input),
        .mem_write         (mem_write),
        .mem_write_address (mem_write_address),
`ifdef CACHE_PERF_CNT_EN
        .hit_count         (hit_count),
        .miss_count        (miss_count),
`endif
        .mem_write_data    (mem_write_data)
    );

    assign mem_we    = mem_write | pre_we;
    assign mem_waddr = pre_we ? pre_addr : mem_write_address;
    assign mem_wdata = pre_we ? pre_data : mem_write_data;

    data_memory #(.ADDR_BITS(8)) u_mem (
        .clk           (clk),
        .write         (mem_we),
        .write_address (mem_waddr),
        .write_data    (mem_wdata),
        .read_address  (mem_read_address),
        .count         (countR),
        .read_data     (mem_input)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int line, input int k);
        return 32'hC0DE_0000 | 32'(line << 4) | 32'(k);
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
        read_in       = rd;
        write_in      = wr;
        address       = addr;
        write_data_in = wdata;
        #1;
    endtask

    // Let the hit cycle take its clock edge, then drop the request.
    task automatic finish_access();
        @(posedge clk);
        @(negedge clk);
        read_in  = 1'b0;
        write_in = 1'b0;
    endtask

    // Called one step after a request was seen to miss; steps until the stall clears.
    task automatic wait_service(input string tag, input int exp_cycles, input int exp_pulses);
        int  n      = 0;
        int  pulses = 0;
        int  bad    = 0;
        bit  done   = 1'b0;
        while (!done && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (!mem_access_status) begin
                done = 1'b1;
            end else begin
                if (countR !== 5'(n % LAT)) bad++;
                if (mem_write === 1'b1) begin
                    pulses++;
                    wb_addr  = mem_write_address;
                    wb_data  = mem_write_data;
                    wb_count = countR;
                end
                n++;
            end
        end
        check({tag, "_done"}, 128'(done), 128'd1);
        check({tag, "_cycles"}, 128'(n), 128'(exp_cycles));
        check({tag, "_countr_seq"}, 128'(bad), 128'd0);
        check({tag, "_wr_pulses"}, 128'(pulses), 128'(exp_pulses));
    endtask

    initial begin
        int guard;
        rst_n         = 1'b0;
        read_in       = 1'b0;
        write_in      = 1'b0;
        address       = '0;
        write_data_in = '0;
        pre_we        = 1'b0;
        pre_addr      = '0;
        pre_data      = '0;

        // Preload backing lines 0..127 while the cache is held in reset.
        for (int l = 0; l < 128; l++) begin
            @(negedge clk);
            pre_we   = 1'b1;
            pre_addr = 32'(l << 4);
            pre_data = {pat(l, 3), pat(l, 2), pat(l, 1), pat(l, 0)};
        end
        @(negedge clk);
        pre_we = 1'b0;
        #1;
        check("rst_status", 128'(mem_access_status), 128'd0);
        check("rst_countr", 128'(countR), 128'd0);
        check("rst_mem_write", 128'(mem_write), 128'd0);
        check("rst_read_data", 128'(read_data), 128'd0);
        check("rst_mem_rd_addr", 128'(mem_read_address), 128'd0);
        check("rst_mem_wr_addr", 128'(mem_write_address), 128'd0);
        check("rst_mem_wr_data", mem_write_data, 128'd0);
`ifdef CACHE_PERF_CNT_EN
        check("rst_hit_count", 128'(hit_count), 128'd0);
        check("rst_miss_count", 128'(miss_count), 128'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Write-allocate into an empty cache: clean miss, refill, then the store hits.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h0000_0000, 32'd9);
        check("wr0_miss_status", 128'(mem_access_status), 128'd1);
        wait_service("wr0", LAT, 0);
        check("wr0_rd_addr", 128'(mem_read_address), 128'h0);
        finish_access();

        // Read hits on the freshly written word and a memory-filled neighbour.
        drive(1'b1, 1'b0, 32'h0000_0000, 32'd0);
        check("rd0_data", 128'(read_data), 128'd9);
        check("rd0_status", 128'(mem_access_status), 128'd0);
        check("rd0_countr", 128'(countR), 128'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0004, 32'd0);
        check("rd4_data", 128'(read_data), 128'(pat(0, 1)));
        check("rd4_status", 128'(mem_access_status), 128'd0);
        finish_access();
        check("hold_data", 128'(read_data), 128'(pat(0, 1)));

        // Conflict miss on a dirty line: write-back then refill.
        drive(1'b1, 1'b0, 32'h0000_0400, 32'd0);
        check("rd400_miss_status", 128'(mem_access_status), 128'd1);
        wait_service("rd400", 2 * LAT, 1);
        check("wb_addr", 128'(wb_addr), 128'h0);
        check("wb_word0", 128'(wb_data[31:0]), 128'd9);
        check("wb_word1", 128'(wb_data[63:32]), 128'(pat(0, 1)));
        check("wb_countr", 128'(wb_count), 128'(LAT - 1));
        check("rd400_rd_addr", 128'(mem_read_address), 128'h400);
        check("rd400_data", 128'(read_data), 128'(pat(64, 0)));
        finish_access();

        // Line 0 evicted clean; refetch shows the written-back store.
        drive(1'b1, 1'b0, 32'h0000_0000, 32'd0);
        check("refetch_miss_status", 128'(mem_access_status), 128'd1);
        wait_service("refetch", LAT, 0);
        check("refetch_data", 128'(read_data), 128'd9);
        finish_access();

        // Simultaneous read and write: old word visible now, new word afterwards.
        drive(1'b1, 1'b1, 32'h0000_0008, 32'h55);
        check("rw8_status", 128'(mem_access_status), 128'd0);
        check("rw8_pre_data", 128'(read_data), 128'(pat(0, 2)));
        finish_access();
        drive(1'b1, 1'b0, 32'h0000_0008, 32'd0);
        check("rd8_data", 128'(read_data), 128'h55);
        finish_access();

        // The collision write must have marked the line dirty.
        drive(1'b1, 1'b0, 32'h0000_0400, 32'd0);
        wait_service("evict2", 2 * LAT, 1);
        check("wb2_word2", 128'(wb_data[95:64]), 128'h55);
        check("wb2_word0", 128'(wb_data[31:0]), 128'd9);
        check("evict2_data", 128'(read_data), 128'(pat(64, 0)));
        finish_access();

        // Reset in the middle of a refill.
        drive(1'b1, 1'b0, 32'h0000_0010, 32'd0);
        check("rd10_miss_status", 128'(mem_access_status), 128'd1);
        guard = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end while (countR != 5'd7 && guard < 100);
        check("midalloc_reached", 128'(countR), 128'd7);
        read_in = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("midrst_countr", 128'(countR), 128'd0);
        check("midrst_status", 128'(mem_access_status), 128'd0);
        check("midrst_mem_write", 128'(mem_write), 128'd0);
`ifdef CACHE_PERF_CNT_EN
        check("midrst_hit_count", 128'(hit_count), 128'd0);
        check("midrst_miss_count", 128'(miss_count), 128'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0010, 32'd0);
        check("post_rst_miss", 128'(mem_access_status), 128'd1);
        wait_service("post_rst", LAT, 0);
        check("post_rst_data", 128'(read_data), 128'(pat(1, 0)));
        finish_access();
`ifdef CACHE_PERF_CNT_EN
        check("final_hit_count", 128'(hit_count), 128'd1);
        check("final_miss_count", 128'(miss_count), 128'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
